// File: rtl/cache_arbiter.sv
// Round-robin arbiter joining the I-cache and D-cache onto one physical-memory port.
// The winner's address, write data and op are latched at grant; responses go only to the winner.
module cache_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic                  i_pmem_resp,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic                  d_pmem_resp,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic [15:0]           i_grant_count,
  output logic [15:0]           d_grant_count
);

  localparam int unsigned CNT_WIDTH = 16;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   last_grant_d;
  logic   op_write;
  logic   i_req;
  logic   d_req;
  logic   grant_i;
  logic   grant_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and grant decision; ties go to whichever side was not served last
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          grant_i = last_grant_d;
          grant_d = ~last_grant_d;
        end else begin
          grant_i = i_req;
          grant_d = d_req;
        end
        if (grant_i) begin
          state_next = I_BUSY;
        end else if (grant_d) begin
          state_next = D_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Strobes decode the registered state; responses are gated off while reset is held
  always_comb begin
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    case (state)
      I_BUSY: begin
        pmem_read   = 1'b1;
        i_pmem_resp = pmem_resp & reset;
      end
      D_BUSY: begin
        pmem_read   = ~op_write;
        pmem_write  = op_write;
        d_pmem_resp = pmem_resp & reset;
      end
      default: ;
    endcase
  end

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  // Transaction latch, round-robin history and saturating grant counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      pmem_address  <= '0;
      pmem_wdata    <= '0;
      op_write      <= 1'b0;
      last_grant_d  <= 1'b0;
      i_grant_count <= '0;
      d_grant_count <= '0;
    end else if (grant_i) begin
      pmem_address <= i_pmem_address;
      op_write     <= 1'b0;
      last_grant_d <= 1'b0;
      if (i_grant_count != CNT_MAX) begin
        i_grant_count <= i_grant_count + CNT_WIDTH'(1);
      end
    end else if (grant_d) begin
      pmem_address <= d_pmem_address;
      op_write     <= d_pmem_write;
      last_grant_d <= 1'b1;
      if (d_pmem_write) begin
        pmem_wdata <= d_pmem_wdata;
      end
      if (d_grant_count != CNT_MAX) begin
        d_grant_count <= d_grant_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: table of transactions plus directed corner sequences,
// with a scoreboard of expected grants/responses checked by a negedge monitor.
module tb_cache_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned LW = 128;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_pmem_read = 1'b0;
  logic [AW-1:0] i_pmem_address = '0;
  logic          i_pmem_resp;
  logic [LW-1:0] i_pmem_rdata;
  logic          d_pmem_read = 1'b0;
  logic          d_pmem_write = 1'b0;
  logic [AW-1:0] d_pmem_address = '0;
  logic [LW-1:0] d_pmem_wdata = '0;
  logic          d_pmem_resp;
  logic [LW-1:0] d_pmem_rdata;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic          pmem_resp = 1'b0;
  logic [LW-1:0] pmem_rdata = '0;
  logic [15:0]   i_grant_count;
  logic [15:0]   d_grant_count;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .reset(reset),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_resp(i_pmem_resp), .i_pmem_rdata(i_pmem_rdata),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_resp(d_pmem_resp), .d_pmem_rdata(d_pmem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .i_grant_count(i_grant_count), .d_grant_count(d_grant_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          side_d;
    bit          wr;
    logic [15:0] addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    int          lat;
    int          req_cyc;
  } txn_t;

  typedef struct {
    bit           rst;
    bit           i_rd;
    bit           d_rd;
    bit           d_wr;
    bit           d_first;
    int           lat;
    logic [15:0]  i_addr;
    logic [15:0]  d_addr;
    logic [127:0] d_wdata;
    logic [127:0] i_rdata;
    logic [127:0] d_rdata;
    logic [15:0]  exp_i;
    logic [15:0]  exp_d;
  } row_t;

  txn_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // Requester intent; the driver process applies it and scrambles inputs while busy
  logic          i_want = 1'b0, d_want_rd = 1'b0, d_want_wr = 1'b0;
  logic          i_keep = 1'b0, d_keep = 1'b0;
  logic [AW-1:0] i_want_addr = '0, d_want_addr = '0;
  logic [LW-1:0] d_want_wdata = '0;
  logic          mem_en = 1'b1;
  logic          allow_unsched = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_txn(input bit side_d, input bit wr, input logic [15:0] addr,
                          input logic [127:0] wdata, input logic [127:0] rdata, input int lat);
    txn_t t;
    t.side_d = side_d; t.wr = wr; t.addr = addr; t.wdata = wdata;
    t.rdata = rdata; t.lat = lat; t.req_cyc = cyc;
    sb.push_back(t);
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d transactions outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    i_want = 1'b0; d_want_rd = 1'b0; d_want_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requester driver
  always @(posedge clk) begin
    #2;
    i_pmem_read  = i_want;
    d_pmem_read  = d_want_rd;
    d_pmem_write = d_want_wr;
    if (pmem_read || pmem_write) begin
      i_pmem_address = AW'($urandom);
      d_pmem_address = AW'($urandom);
      d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
    end else begin
      i_pmem_address = i_want_addr;
      d_pmem_address = d_want_addr;
      d_pmem_wdata   = d_want_wdata;
    end
  end

  // Memory model: answers the scoreboard head after its latency
  int mcnt = 0;
  always @(posedge clk) begin
    #1;
    if (mem_en) begin
      if (pmem_resp) begin
        pmem_resp  = 1'b0;
        mcnt       = 0;
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end else if ((pmem_read || pmem_write) && sb.size() != 0) begin
        if (mcnt == sb[0].lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = sb[0].rdata;
        end else begin
          mcnt++;
          pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
      end else begin
        mcnt       = 0;
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // Monitor: grant timing/contents, held latches, response routing and timing
  logic prev_strobe = 1'b0, prev_resp = 1'b0;
  int   start_cyc = 0, last_resp_cyc = -100;
  always @(negedge clk) begin
    logic strobe;
    txn_t t;
    int   exp_start;
    strobe = pmem_read | pmem_write;
    if (reset) begin
      if (prev_resp) chk("turnaround_idle", LW'(strobe), LW'(0));
      if (strobe && !prev_strobe) begin
        if (sb.size() == 0) begin
          if (!allow_unsched) begin
            checks++; errors++;
            $display("FAIL unexpected_grant: addr %h, expected no grant", pmem_address);
          end
        end else begin
          t = sb[0];
          exp_start = (t.req_cyc + 1 > last_resp_cyc + 2) ? t.req_cyc + 1 : last_resp_cyc + 2;
          chk("grant_cycle", LW'(cyc), LW'(exp_start));
          chk("strobe_rw", LW'({pmem_read, pmem_write}), t.wr ? LW'(2'b01) : LW'(2'b10));
          start_cyc = cyc;
        end
      end
      if (strobe && sb.size() != 0) begin
        chk("addr_held", LW'(pmem_address), LW'(sb[0].addr));
        if (sb[0].wr) chk("wdata_held", pmem_wdata, sb[0].wdata);
      end
      if (i_pmem_resp || d_pmem_resp) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: i=%0b d=%0b expected none", i_pmem_resp, d_pmem_resp);
        end else begin
          t = sb.pop_front();
          chk("resp_side", LW'({i_pmem_resp, d_pmem_resp}), t.side_d ? LW'(2'b01) : LW'(2'b10));
          chk("resp_rdata", t.side_d ? d_pmem_rdata : i_pmem_rdata, t.rdata);
          chk("resp_cycle", LW'(cyc), LW'(start_cyc + t.lat));
          last_resp_cyc = cyc;
          if (t.side_d && !d_keep) begin
            d_want_rd = 1'b0;
            d_want_wr = 1'b0;
          end
          if (!t.side_d && !i_keep) i_want = 1'b0;
        end
      end
    end
    prev_strobe = strobe;
    prev_resp   = i_pmem_resp | d_pmem_resp;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    row_t rows[7];
    int   n;
    rows[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5, 16'h0040, 16'h0000, 128'h0,
                {16{8'hA5}}, 128'h0, 16'd1, 16'd0};
    rows[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 16'h0000, 16'h1230,
                128'h0123456789ABCDEF0123456789ABCDEF, 128'h0, 128'h5A, 16'd1, 16'd1};
    rows[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2, 16'h0100, 16'h2000, 128'h0,
                {8{16'h1111}}, {8{16'h2222}}, 16'd1, 16'd1};
    rows[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 16'h0000, 16'h3000, 128'h0,
                128'h0, {8{16'h3333}}, 16'd1, 16'd2};
    rows[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4, 16'h0140, 16'h3040, 128'h0,
                {8{16'h4444}}, {8{16'h5555}}, 16'd2, 16'd3};
    rows[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2, 16'h0000, 16'h4440,
                {4{32'hFEEDBEEF}}, 128'h0, {8{16'h6666}}, 16'd2, 16'd4};
    rows[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 16'h0180, 16'h0000, 128'h0,
                {8{16'h7777}}, 128'h0, 16'd3, 16'd4};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", LW'({pmem_read, pmem_write}), LW'(0));
    chk("rst_addr", LW'(pmem_address), LW'(0));
    chk("rst_wdata", pmem_wdata, LW'(0));
    chk("rst_counts", LW'({i_grant_count, d_grant_count}), LW'(0));
    chk("rst_resp", LW'({i_pmem_resp, d_pmem_resp}), LW'(0));
    reset = 1'b1;

    for (int r = 0; r < 7; r++) begin
      @(posedge clk); #1;
      if (rows[r].rst) apply_reset();
      i_want_addr  = rows[r].i_addr;
      d_want_addr  = rows[r].d_addr;
      d_want_wdata = rows[r].d_wdata;
      if (rows[r].i_rd && (rows[r].d_rd || rows[r].d_wr) && !rows[r].d_first)
        push_txn(1'b0, 1'b0, rows[r].i_addr, 128'h0, rows[r].i_rdata, rows[r].lat);
      if (rows[r].d_rd || rows[r].d_wr)
        push_txn(1'b1, rows[r].d_wr, rows[r].d_addr, rows[r].d_wdata, rows[r].d_rdata, rows[r].lat);
      if (rows[r].i_rd && !((rows[r].d_rd || rows[r].d_wr) && !rows[r].d_first))
        push_txn(1'b0, 1'b0, rows[r].i_addr, 128'h0, rows[r].i_rdata, rows[r].lat);
      i_want    = rows[r].i_rd;
      d_want_rd = rows[r].d_rd;
      d_want_wr = rows[r].d_wr;
      wait_empty(100);
      chk("row_i_count", LW'(i_grant_count), LW'(rows[r].exp_i));
      chk("row_d_count", LW'(d_grant_count), LW'(rows[r].exp_d));
      repeat (2) @(posedge clk);
    end

    // Reset while D_BUSY, then a late pmem_resp in IDLE
    allow_unsched = 1'b1;
    mem_en = 1'b0;
    pmem_resp = 1'b0;
    @(posedge clk); #1;
    d_want_addr = 16'h5550;
    d_want_rd = 1'b1;
    n = 0;
    while (!pmem_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_rst_granted", LW'(pmem_read), LW'(1));
    @(posedge clk); #1;
    reset = 1'b0;
    pmem_resp = 1'b1;
    d_want_rd = 1'b0;
    @(negedge clk);
    chk("mid_rst_resp_gated", LW'({i_pmem_resp, d_pmem_resp}), LW'(0));
    @(posedge clk); #1;
    chk("mid_rst_strobes", LW'({pmem_read, pmem_write}), LW'(0));
    chk("mid_rst_addr", LW'(pmem_address), LW'(0));
    chk("mid_rst_wdata", pmem_wdata, LW'(0));
    chk("mid_rst_counts", LW'({i_grant_count, d_grant_count}), LW'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("idle_resp_ignored", LW'({i_pmem_resp, d_pmem_resp}), LW'(0));
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    mem_en = 1'b1;
    allow_unsched = 1'b0;

    // Both held for six transactions: D, I, D, I, D, I
    @(posedge clk); #1;
    i_keep = 1'b1; d_keep = 1'b1;
    i_want_addr = 16'h0A00;
    d_want_addr = 16'h0D00;
    for (int k = 0; k < 6; k++)
      push_txn((k % 2) == 0, 1'b0, ((k % 2) == 0) ? 16'h0D00 : 16'h0A00, 128'h0,
               {4{32'(k + 32'hC0DE0000)}}, 1);
    i_want = 1'b1;
    d_want_rd = 1'b1;
    wait_empty(200);
    i_keep = 1'b0; d_keep = 1'b0;
    i_want = 1'b0; d_want_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("alt_i_count", LW'(i_grant_count), LW'(3));
    chk("alt_d_count", LW'(d_grant_count), LW'(3));

    // Saturation of the D grant counter
    force dut.d_grant_count = 16'hFFFE;
    @(posedge clk); #1;
    release dut.d_grant_count;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      d_want_addr = 16'h6000 + 16'(k * 16);
      push_txn(1'b1, 1'b0, d_want_addr, 128'h0, {4{32'(k + 32'h5A700000)}}, 2);
      d_want_rd = 1'b1;
      wait_empty(100);
      chk("d_count_sat", LW'(d_grant_count), LW'(16'hFFFF));
      chk("i_count_steady", LW'(i_grant_count), LW'(3));
    end
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-port physical-memory arbiter between the split L1 caches (I_CACHE, D_CACHE) and the single 128-bit physical-memory port of `mp3`. It accepts line-fill reads from the instruction cache and line reads/write-backs from the data cache. It grants one requester at a time with round-robin tie-breaking and latches that requester's address and write data for the whole transaction. It routes the memory response back only to the granted cache and keeps saturating grant counters for performance monitoring.

## Interface
- ADDR_WIDTH, 16, physical address width (lc3b_word)
- LINE_WIDTH, 128, cache line width in bits
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0)
- i_pmem_read  in  1  I-cache line-read request, held until i_pmem_resp
- i_pmem_address  in  ADDR_WIDTH  I-cache line address
- i_pmem_resp  out  1  I-cache transaction complete (1-cycle pulse)
- i_pmem_rdata  out  LINE_WIDTH  line data to I-cache, valid with i_pmem_resp
- d_pmem_read  in  1  D-cache line-read request, held until d_pmem_resp
- d_pmem_write  in  1  D-cache write-back request, held until d_pmem_resp
- d_pmem_address  in  ADDR_WIDTH  D-cache line address
- d_pmem_wdata  in  LINE_WIDTH  D-cache write-back data
- d_pmem_resp  out  1  D-cache transaction complete (1-cycle pulse)
- d_pmem_rdata  out  LINE_WIDTH  line data to D-cache, valid with d_pmem_resp
- pmem_read  out  1  read strobe to physical memory
- pmem_write  out  1  write strobe to physical memory
- pmem_address  out  ADDR_WIDTH  latched address of granted transaction
- pmem_wdata  out  LINE_WIDTH  latched write data of granted transaction
- pmem_resp  in  1  physical memory done
- pmem_rdata  in  LINE_WIDTH  physical memory read data
- i_grant_count  out  16  number of I grants, saturating at 16'hFFFF
- d_grant_count  out  16  number of D grants, saturating at 16'hFFFF

## Operation
- States: IDLE, I_BUSY, D_BUSY.
- IDLE: i_req = i_pmem_read; d_req = d_pmem_read | d_pmem_write.
  - Only i_req: go to I_BUSY.
  - Only d_req: go to D_BUSY.
  - Both: grant the port not granted last (last_grant register). Reset value of last_grant = I, so the first tie goes to D.
  - Neither: stay in IDLE.
- On the grant edge:
  - Latch pmem_address from the winner's address.
  - Latch pmem_wdata from d_pmem_wdata on a D write; otherwise hold its previous value.
  - Latch the op type.
  - Update last_grant.
  - Increment the winner's grant counter unless it is already 16'hFFFF.
- I_BUSY: pmem_read = 1, pmem_write = 0.
- D_BUSY: pmem_write = 1 if d_pmem_write was set at grant, otherwise pmem_read = 1. If d_pmem_read and d_pmem_write are both set at grant, write wins.
- Response in a BUSY state:
  - When pmem_resp = 1: pmem_rdata and the resp pulse go combinationally to the granted side only. The other side's resp stays 0.
  - Next state is IDLE.
- Requester inputs are ignored while BUSY; latched values are not re-sampled.
- i_pmem_rdata / d_pmem_rdata mirror pmem_rdata at all times. They are meaningful only with their resp.
- pmem_resp seen in IDLE is ignored and not forwarded.
- Reset (reset = 0 at a clock edge), including mid-transaction:
  - state = IDLE, last_grant = I.
  - pmem_read = pmem_write = 0, pmem_address = 0, pmem_wdata = 0.
  - Both grant counters = 0.
  - i_pmem_resp = d_pmem_resp = 0 while reset is low.

## Timing
- Grant latency: request high in IDLE at edge N; pmem_read/pmem_write and pmem_address are valid from cycle N+1.
- Completion: pmem_resp high in cycle M gives the requester resp in the same cycle M, with no added latency. Strobes drop and state is IDLE from M+1.
- Turnaround: at least one IDLE cycle between transactions. A new grant is sampled at edge M+1, and strobes reassert at M+2 at the earliest. This also keeps a stale request from being re-granted.
- Strobes are registered state decodes. They never change mid-cycle.
- Back-to-back ties alternate D, I, D, I…; no port starves.

## Test plan
- Single I read at address 16'h0040: pmem_read rises 1 cycle after i_pmem_read, pmem_address = 16'h0040. Memory answers after 5 cycles with rdata = 128'hA5…A5. Expected: i_pmem_resp pulse with that data, d_pmem_resp = 0, i_grant_count = 1.
- D write-back at 16'h1230 with wdata = 128'h0123…CDEF: pmem_write = 1 with the latched data. Changing d_pmem_wdata mid-transaction must not change pmem_wdata. Expected: d_pmem_resp on pmem_resp.
- Simultaneous I read at 16'h0100 and D read at 16'h2000 from reset: D served first. I served second, with pmem_read reasserted exactly 2 cycles after D's resp. Expected: both counts = 1.
- Both requesters held continuously for 6 transactions: grant order D, I, D, I, D, I. Expected: counts 3/3, with a 1-cycle IDLE gap each time.
- Reset low during D_BUSY: strobes = 0 on the next edge. A pmem_resp arriving afterwards produces no requester resp. Expected: counters = 0.
- Preload d_grant_count = 16'hFFFE, then run 3 D transactions. Expected: d_grant_count holds at 16'hFFFF.
